cvsd_decoder: RTL and testbench

Receive-side CVSD block. It converts the 1-bit CVSD stream back into an 8-bit unsigned waveform.
- Mirrors the encoder: same bit history, coincidence detection, step adaptation and saturating integrator.
- Fed the encoder's bit stream with matching parameters, its integrator output equals the encoder's xp sample for sample.
- A first-order smoothing filter then produces the final analog-equivalent output.

---
 rtl/cvsd_pkg.sv | 22 ++
 rtl/cvsd_decoder_if.sv | 22 ++
 rtl/cvsd_step_adapt.sv | 55 +++++
 rtl/cvsd_decoder.sv | 69 ++++++
 tb/tb_cvsd_decoder.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cvsd_pkg.sv
// Shared CVSD constants and helpers; imported by encoder and decoder so both adapt identically.
package cvsd_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned MIDSCALE    = 1 << (DATA_W - 1);
    localparam int unsigned STEP_W      = 6;
    localparam int unsigned EXT_W       = DATA_W + 2;
    localparam int unsigned RUN_LEN     = 3;
    localparam int unsigned STEP_MIN    = 1;
    localparam int unsigned STEP_MAX    = 32;
    localparam int unsigned STEP_INC    = 2;
    localparam int unsigned DECAY_SHIFT = 3;
    localparam int unsigned FILT_SHIFT  = 2;

    // Saturate a signed extended-width value into the unsigned sample range.
    function automatic logic [DATA_W-1:0] clamp_sample(input logic signed [EXT_W-1:0] v);
        if (v[EXT_W-1]) return '0;
        if (|v[EXT_W-2:DATA_W]) return '1;
        return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/cvsd_decoder_if.sv
// Bit-stream input and reconstruction outputs of the CVSD decoder.
interface cvsd_decoder_if;

    logic                          bit_in;
    logic                          bit_valid;
    logic [cvsd_pkg::DATA_W-1:0]   xp_out;
    logic [cvsd_pkg::DATA_W-1:0]   y_out;
    logic                          out_valid;
    logic                          flag;
    logic [cvsd_pkg::STEP_W-1:0]   step_out;

    modport master (
        output bit_in, bit_valid,
        input  xp_out, y_out, out_valid, flag, step_out
    );

    modport slave (
        input  bit_in, bit_valid,
        output xp_out, y_out, out_valid, flag, step_out
    );

endinterface

// File: rtl/cvsd_step_adapt.sv
// Bit history, coincidence detection and step-size adaptation shared by encoder and decoder.
module cvsd_step_adapt
    import cvsd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              bit_in,
    output logic [STEP_W-1:0] step,
    output logic [STEP_W-1:0] step_next_c,
    output logic              flag
);

    localparam int unsigned FILL_W = $clog2(RUN_LEN + 1);
    localparam int unsigned UP_W   = STEP_W + 1;

    logic [RUN_LEN-1:0] hist;
    logic [RUN_LEN-1:0] hist_new;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_new;
    logic               coin_c;
    logic [UP_W-1:0]    up;
    logic [STEP_W-1:0]  dec;
    logic [STEP_W-1:0]  down;

    // Fill count keeps a partially filled history after reset from faking a run.
    always_comb begin
        hist_new = {hist[RUN_LEN-2:0], bit_in};
        fill_new = (fill == FILL_W'(RUN_LEN)) ? fill : fill + FILL_W'(1);
        coin_c   = (fill_new == FILL_W'(RUN_LEN)) && ((&hist_new) || !(|hist_new));

        up   = UP_W'(step) + UP_W'(STEP_INC);
        dec  = step >> DECAY_SHIFT;
        if (dec == '0 && step > STEP_W'(STEP_MIN)) dec = STEP_W'(1);
        down = step - dec;

        if (coin_c) step_next_c = (up > UP_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : up[STEP_W-1:0];
        else        step_next_c = (down < STEP_W'(STEP_MIN)) ? STEP_W'(STEP_MIN) : down;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
            step <= STEP_W'(STEP_MIN);
            flag <= 1'b0;
        end else if (en) begin
            hist <= hist_new;
            fill <= fill_new;
            step <= step_next_c;
            flag <= coin_c;
        end
    end

endmodule

// File: rtl/cvsd_decoder.sv
// CVSD receiver: adaptive-step integrator followed by a first-order smoothing filter.
module cvsd_decoder
    import cvsd_pkg::*;
(
    input  logic           CLOCK,
    input  logic           RESET,
    cvsd_decoder_if.slave  bus
);

    logic [STEP_W-1:0]        step;
    logic [STEP_W-1:0]        step_next_c;
    logic                     flag;
    logic [DATA_W-1:0]        xp;
    logic [DATA_W-1:0]        y;
    logic                     stage2;
    logic                     out_valid;

    logic signed [EXT_W-1:0]  xp_ext;
    logic signed [EXT_W-1:0]  step_ext;
    logic signed [EXT_W-1:0]  xp_sum;
    logic signed [EXT_W-1:0]  y_ext;
    logic signed [EXT_W-1:0]  err;
    logic signed [EXT_W-1:0]  delta;
    logic signed [EXT_W-1:0]  y_sum;

    cvsd_step_adapt u_step (
        .clk         (CLOCK),
        .rst         (RESET),
        .en          (bus.bit_valid),
        .bit_in      (bus.bit_in),
        .step        (step),
        .step_next_c (step_next_c),
        .flag        (flag)
    );

    // Integrator uses the freshly adapted step; filter always moves at least one LSB toward xp.
    always_comb begin
        xp_ext   = EXT_W'(xp);
        step_ext = EXT_W'(step_next_c);
        xp_sum   = bus.bit_in ? (xp_ext + step_ext) : (xp_ext - step_ext);

        y_ext = EXT_W'(y);
        err   = xp_ext - y_ext;
        delta = err >>> FILT_SHIFT;
        if (delta == '0 && err != '0) delta = err[EXT_W-1] ? '1 : EXT_W'(1);
        y_sum = y_ext + delta;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            xp        <= DATA_W'(MIDSCALE);
            y         <= DATA_W'(MIDSCALE);
            stage2    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            stage2    <= bus.bit_valid;
            out_valid <= stage2;
            if (bus.bit_valid) xp <= clamp_sample(xp_sum);
            if (stage2)        y  <= clamp_sample(y_sum);
        end
    end

    assign bus.xp_out    = xp;
    assign bus.y_out     = y;
    assign bus.out_valid = out_valid;
    assign bus.flag      = flag;
    assign bus.step_out  = step;

endmodule

// File: tb/tb_cvsd_decoder.sv
// Self-checking bench for cvsd_decoder against a run-length based behavioural model.
module tb_cvsd_decoder;
    import cvsd_pkg::*;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLOCK = ~CLOCK;

    cvsd_decoder_if bus();

    cvsd_decoder dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state (plain integers, run length instead of a shift history)
    int m_xp, m_y, m_step, m_run;
    bit m_last, m_flag, m_pend, m_ov;

    function automatic int clampi(int v);
        int hi;
        hi = (1 << DATA_W) - 1;
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int next_step(int step, bit coin);
        int d, smin, smax, sinc;
        smin = int'(STEP_MIN);
        smax = int'(STEP_MAX);
        sinc = int'(STEP_INC);
        if (coin) return (step + sinc > smax) ? smax : step + sinc;
        d = step >> DECAY_SHIFT;
        if (d == 0 && step > smin) d = 1;
        return (step - d < smin) ? smin : step - d;
    endfunction

    task automatic model_reset();
        m_xp = int'(MIDSCALE); m_y = int'(MIDSCALE); m_step = int'(STEP_MIN);
        m_run = 0; m_last = 1'b0; m_flag = 1'b0; m_pend = 1'b0; m_ov = 1'b0;
    endtask

    task automatic model_edge(bit rst, bit v, bit b);
        int e, d;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_pend) begin
            e = m_xp - m_y;
            d = e >>> FILT_SHIFT;
            if (d == 0 && e != 0) d = (e < 0) ? -1 : 1;
            m_y = clampi(m_y + d);
        end
        m_ov = m_pend;
        if (v) begin
            m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
            m_last = b;
            m_flag = (m_run >= int'(RUN_LEN));
            m_step = next_step(m_step, m_flag);
            m_xp   = clampi(b ? m_xp + m_step : m_xp - m_step);
        end
        m_pend = v;
    endtask

    function automatic logic [23:0] exp_state();
        return {8'(m_xp), 8'(m_y), 6'(m_step), m_flag, m_ov};
    endfunction

    function automatic logic [23:0] dut_state();
        return {bus.xp_out, bus.y_out, bus.step_out, bus.flag, bus.out_valid};
    endfunction

    // One clock: drive at negedge, advance model at posedge, leave time at posedge+1 for sampling.
    task automatic cyc(bit rst, bit v, bit b);
        @(negedge CLOCK);
        RESET = rst; bus.bit_valid = v; bus.bit_in = b;
        @(posedge CLOCK);
        model_edge(rst, v, b);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)));
            total++;
            if (dut_state() !== {8'd128, 8'd128, 6'd1, 1'b0, 1'b0}) begin
                bad++; $display("FAIL reset[%0d] got=%h exp=%h", i, dut_state(), {8'd128, 8'd128, 6'd1, 2'b00});
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (bus.out_valid !== 1'b0 || bus.xp_out !== 8'd128) begin
            bad++; $display("FAIL reset_release got ov=%b xp=%0d exp ov=0 xp=128", bus.out_valid, bus.xp_out);
        end
    endtask

    task automatic test_alternating();
        int exp_xp[4] = '{129, 128, 129, 128};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'(~i[0]));
            total++;
            if (bus.xp_out !== 8'(exp_xp[i]) || bus.step_out !== 6'd1 || bus.flag !== 1'b0 || bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL alt_s1[%0d] got xp=%0d step=%0d flag=%b ov=%b exp xp=%0d step=1 flag=0 ov=0",
                                i, bus.xp_out, bus.step_out, bus.flag, bus.out_valid, exp_xp[i]);
            end
            cyc(1'b0, 1'b0, 1'b0);
            total++;
            if (bus.out_valid !== 1'b1 || dut_state() !== exp_state()) begin
                bad++; $display("FAIL alt_s2[%0d] got=%h exp=%h", i, dut_state(), exp_state());
            end
        end
    endtask

    task automatic test_five_ones();
        int exp_step[5] = '{1, 1, 3, 5, 7};
        int exp_xp[5]   = '{129, 130, 133, 138, 145};
        bit exp_flag[5] = '{0, 0, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            total++;
            if (bus.step_out !== 6'(exp_step[i]) || bus.xp_out !== 8'(exp_xp[i]) || bus.flag !== exp_flag[i]) begin
                bad++; $display("FAIL ones[%0d] got step=%0d xp=%0d flag=%b exp step=%0d xp=%0d flag=%b",
                                i, bus.step_out, bus.xp_out, bus.flag, exp_step[i], exp_xp[i], exp_flag[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_step[3] = '{28, 25, 22};
        int exp_xp[3]   = '{227, 252, 230};
        int prev;
        do_reset();
        prev = 128;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            total++;
            if (dut_state() !== exp_state() || int'(bus.xp_out) < prev) begin
                bad++; $display("FAIL sat[%0d] got=%h exp=%h prev_xp=%0d", i, dut_state(), exp_state(), prev);
            end
            prev = int'(bus.xp_out);
        end
        total++;
        if (bus.step_out !== 6'd32 || bus.xp_out !== 8'd255) begin
            bad++; $display("FAIL sat_end got step=%0d xp=%0d exp step=32 xp=255", bus.step_out, bus.xp_out);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'(i[0]));
            total++;
            if (bus.step_out !== 6'(exp_step[i]) || bus.xp_out !== 8'(exp_xp[i]) || bus.flag !== 1'b0) begin
                bad++; $display("FAIL decay[%0d] got step=%0d xp=%0d flag=%b exp step=%0d xp=%0d flag=0",
                                i, bus.step_out, bus.xp_out, bus.flag, exp_step[i], exp_xp[i]);
            end
        end
    endtask

    task automatic test_smoothing();
        int prev;
        do_reset();
        prev = 128;
        for (int i = 0; i < 80; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            total++;
            if (dut_state() !== exp_state() || int'(bus.y_out) < prev) begin
                bad++; $display("FAIL smooth[%0d] got=%h exp=%h prev_y=%0d", i, dut_state(), exp_state(), prev);
            end
            prev = int'(bus.y_out);
        end
        total++;
        if (bus.y_out !== 8'd255 || bus.xp_out !== 8'd255) begin
            bad++; $display("FAIL smooth_final got y=%0d xp=%0d exp y=255 xp=255", bus.y_out, bus.xp_out);
        end
    endtask

    task automatic test_idle_hold();
        logic [23:0] held;
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        held = exp_state();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            total++;
            if (dut_state() !== held) begin
                bad++; $display("FAIL idle[%0d] got=%h exp=%h", i, dut_state(), held);
            end
        end
    endtask

    task automatic test_reset_midpipe();
        do_reset();
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        total++;
        if (bus.out_valid !== 1'b0 || bus.xp_out !== 8'd128 || bus.step_out !== 6'd1) begin
            bad++; $display("FAIL midrst got ov=%b xp=%0d step=%0d exp ov=0 xp=128 step=1", bus.out_valid, bus.xp_out, bus.step_out);
        end
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (bus.out_valid !== 1'b0 || bus.y_out !== 8'd128) begin
            bad++; $display("FAIL midrst_after got ov=%b y=%0d exp ov=0 y=128", bus.out_valid, bus.y_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            total++;
            if (dut_state() !== exp_state()) begin
                bad++; $display("FAIL b2b[%0d] got=%h exp=%h", i, dut_state(), exp_state());
            end
        end
    endtask

    // Loopback against an independent encoder model that chooses bits from a noisy sine.
    task automatic test_loopback();
        int  e_xp, e_step, e_run, x;
        bit  e_last, b, coin;
        real ph;
        do_reset();
        e_xp = int'(MIDSCALE); e_step = int'(STEP_MIN); e_run = 0; e_last = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) begin
                cyc(1'b1, 1'b1, 1'b1);
                e_xp = int'(MIDSCALE); e_step = int'(STEP_MIN); e_run = 0; e_last = 1'b0;
                total++;
                if (bus.xp_out !== 8'd128 || bus.y_out !== 8'd128 || bus.step_out !== 6'd1) begin
                    bad++; $display("FAIL loop_rst got xp=%0d y=%0d step=%0d exp 128/128/1", bus.xp_out, bus.y_out, bus.step_out);
                end
            end
            ph = 2.0 * 3.14159265 * real'(n) / 50.0;
            x  = 128 + int'(100.0 * $sin(ph)) + int'($urandom_range(0, 6)) - 3;
            b  = (x >= e_xp);
            e_run  = (e_run > 0 && b == e_last) ? e_run + 1 : 1;
            e_last = b;
            coin   = (e_run >= int'(RUN_LEN));
            e_step = next_step(e_step, coin);
            e_xp   = clampi(b ? e_xp + e_step : e_xp - e_step);
            if ($urandom_range(0, 2) == 0) cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, b);
            total++;
            if (bus.xp_out !== 8'(e_xp) || dut_state() !== exp_state()) begin
                bad++; $display("FAIL loop[%0d] got xp=%0d state=%h exp xp=%0d state=%h",
                                n, bus.xp_out, dut_state(), e_xp, exp_state());
            end
        end
    endtask

    initial begin
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        model_reset();
        test_reset();
        test_alternating();
        test_five_ones();
        test_saturation();
        test_smoothing();
        test_idle_hold();
        test_reset_midpipe();
        test_back_to_back();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
